ccg_sig_harness: RTL and testbench
==================================

# ccg_sig_harness

Parametrised stimulus and signature-compaction harness for combinational benchmark netlists (x-inputs, f-outputs) in the CCG dataset. It drives an attached netlist with exhaustive or pseudo-random vectors and folds each response into a MISR. The resulting signature lets ORIGINAL and BALANCED variants of one benchmark be proven equivalent in hardware. It replaces fixed-width, purely combinational benchmark checking with a width- and latency-generic sequential engine.

## Interface
- N_IN, 13: number of netlist inputs (stimulus width).
- N_OUT, 16: number of netlist outputs; also the MISR width.
- DUT_LAT, 0: cycles from `stim` to its matching `resp` (0 = combinational netlist). Range 0..7.
- LFSR_POLY, 'h100D: Galois mask for the right-shift stimulus LFSR, N_IN bits.
- MISR_POLY, 'h1021: feedback mask for the left-shift MISR, N_OUT bits.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- mode  in  1  0 = exhaustive, 1 = LFSR; sampled with `start`.
- seed  in  N_IN  LFSR seed; sampled with `start`.
- n_vec  in  N_IN+1  vector count in LFSR mode; sampled with `start`.
- stim  out  N_IN  vector driven to the netlist x-inputs.
- stim_valid  out  1  `stim` carries a live vector this cycle.
- resp  in  N_OUT  netlist f-outputs.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse; the signature is final.
- signature  out  N_OUT  MISR contents.
- vec_cnt  out  N_IN+1  responses absorbed in the current or last run.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE + start:
  - Latch mode, seed and n_vec.
  - Clear signature and vec_cnt.
  - Go to RUN.
  - Exception: if mode=1 and n_vec=0, go straight to DONE.
- RUN: issue one vector per cycle with stim_valid=1.
  - Exhaustive: stim = 0, 1, … 2^N_IN−1; total 2^N_IN vectors.
  - LFSR: first stim = seed, with seed 0 replaced by 1. Next = (s>>1) ^ (s[0] ? LFSR_POLY : 0). Total n_vec vectors.
  - After the last vector: go to DRAIN if DUT_LAT>0, else DONE.
- DRAIN: stim_valid=0; stim holds the last vector. Stay DUT_LAT cycles, then go to DONE.
- Response capture: a DUT_LAT-deep shift of stim_valid marks which resp samples are live.
- MISR update, on each live sample only: sig = (sig<<1)[N_OUT−1:0] ^ (sig[N_OUT−1] ? MISR_POLY : 0) ^ resp.
  - vec_cnt increments on each live sample and saturates at its maximum.
- DONE: done=1 for one cycle, then IDLE. signature and vec_cnt hold until the next accepted start.
- start while busy or in DONE is ignored; it is not queued.
- mode, seed and n_vec changing mid-run have no effect.

## Timing
- Reset values:
  - State IDLE.
  - stim=0, stim_valid=0, busy=0, done=0.
  - signature=0, vec_cnt=0.
  - LFSR/MISR registers and delay line all 0.
- Reset mid-run aborts immediately. No done pulse is produced, and the partial signature is cleared.
- Start latency: start high at edge t → stim_valid=1 with the first vector from t+1.
- Vector k is driven in cycle t+1+k. Its response is sampled at the end of cycle t+1+k+DUT_LAT.
- Total run length for V vectors: done is high in cycle t+1+V+DUT_LAT.
- Back-to-back: the earliest next start is accepted in the cycle after done, i.e. the first IDLE cycle.
- Exhaustive wrap: the counter stops at all-ones; it never wraps back to 0 within a run.
- LFSR mode with n_vec > 2^N_IN−1 repeats the sequence; repetition is legal.
- vec_cnt reaches 2^N_IN in exhaustive mode, hence its width of N_IN+1.

## Test plan
- Zero netlist: resp ≡ 0, mode=0, defaults → done at cycle 1+8192 after start, signature=0x0000, vec_cnt=8192.
- Single and double vector: mode=1, n_vec=1, resp=0xA5A5 → signature=0xA5A5, done 2 cycles after start.
  - n_vec=2, resp 0x8000 then 0x0000 → signature=0x1021.
- LFSR sequence: seed=1 → stim = 0x0001, 0x100D, 0x180B.
  - seed=0 → same sequence.
  - n_vec=0 → done in the cycle after start, vec_cnt=0.
- Latency: DUT_LAT=3 with a registered identity netlist (resp = stim zero-extended, delayed 3).
  - Signature must equal that of the DUT_LAT=0 run with a combinational identity.
  - done arrives 3 cycles later.
- Abort and ignore: assert rst for 1 cycle mid-RUN → all outputs at reset values, no done.
  - Restart completes normally.
  - start pulsed during RUN is ignored: vec_cnt and run length are unchanged.
- Equivalence use-case: the same benchmark's ORIGINAL and BALANCED netlists on two instances, exhaustive mode → identical signatures.
  - A single injected gate inversion → the signatures differ.

Source files
------------

// File: rtl/ccg_sig_harness.sv
// Stimulus and MISR signature harness for combinational benchmark netlists.
// Drives exhaustive or LFSR vectors and compacts the delayed responses.
module ccg_sig_harness #(
    parameter int               N_IN      = 13,
    parameter int               N_OUT     = 16,
    parameter int               DUT_LAT   = 0,
    parameter logic [N_IN-1:0]  LFSR_POLY = 'h100D,
    parameter logic [N_OUT-1:0] MISR_POLY = 'h1021
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [N_IN-1:0]  seed,
    input  logic [N_IN:0]    n_vec,
    output logic [N_IN-1:0]  stim,
    output logic             stim_valid,
    input  logic [N_OUT-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] signature,
    output logic [N_IN:0]    vec_cnt,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int              DLY_W      = (DUT_LAT > 0) ? DUT_LAT : 1;
    localparam logic [N_IN:0]   EXH_COUNT  = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN:0]   ONE_CNT    = {{N_IN{1'b0}}, 1'b1};
    localparam logic [N_IN-1:0] ONE_STIM   = {{(N_IN-1){1'b0}}, 1'b1};
    localparam logic [2:0]      DRAIN_LAST = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    state_t            r_state;
    state_t            w_next;
    logic              r_mode;
    logic [N_IN-1:0]   r_stim;
    logic [N_IN:0]     r_left;
    logic [2:0]        r_drain;
    logic [DLY_W-1:0]  r_vld_dly;
    logic [N_OUT-1:0]  r_sig;
    logic [N_IN:0]     r_vec_cnt;

    logic              w_accept;
    logic              w_last;
    logic              w_valid;
    logic              w_live;
    logic [N_IN-1:0]   w_seed_eff;
    logic [N_IN-1:0]   w_lfsr_next;
    logic [N_IN-1:0]   w_exh_next;
    logic [N_OUT-1:0]  w_sig_next;

    // stim_valid handshake: no back-pressure; the netlist takes one vector every
    // cycle stim_valid is high, and its response is live DUT_LAT cycles later.
    assign w_valid     = (r_state == S_RUN);
    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_last      = (r_left == ONE_CNT);
    assign w_seed_eff  = (seed == '0) ? ONE_STIM : seed;
    assign w_lfsr_next = (r_stim >> 1) ^ (r_stim[0] ? LFSR_POLY : '0);
    // Exhaustive counter saturates at all-ones rather than wrapping.
    assign w_exh_next  = (r_stim == '1) ? r_stim : r_stim + ONE_STIM;
    assign w_sig_next  = {r_sig[N_OUT-2:0], 1'b0} ^ (r_sig[N_OUT-1] ? MISR_POLY : '0) ^ resp;
    assign w_live      = (DUT_LAT == 0) ? w_valid : r_vld_dly[DLY_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (mode && (n_vec == '0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = (DUT_LAT > 0) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (r_drain == 3'd0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= 1'b0;
            r_stim  <= '0;
            r_left  <= '0;
            r_drain <= 3'd0;
        end else if (w_accept) begin
            r_mode <= mode;
            r_left <= mode ? n_vec : EXH_COUNT;
            r_stim <= mode ? w_seed_eff : '0;
        end else if (r_state == S_RUN) begin
            r_left <= r_left - ONE_CNT;
            if (w_last) begin
                r_drain <= DRAIN_LAST;
            end else begin
                r_stim <= r_mode ? w_lfsr_next : w_exh_next;
            end
        end else if ((r_state == S_DRAIN) && (r_drain != 3'd0)) begin
            r_drain <= r_drain - 3'd1;
        end
    end

    // Delay line marking which resp samples belong to issued vectors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_dly <= '0;
        end else begin
            r_vld_dly <= (r_vld_dly << 1) | DLY_W'(w_valid);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig     <= '0;
            r_vec_cnt <= '0;
        end else if (w_accept) begin
            r_sig     <= '0;
            r_vec_cnt <= '0;
        end else if (w_live) begin
            r_sig <= w_sig_next;
            if (r_vec_cnt != '1) begin
                r_vec_cnt <= r_vec_cnt + ONE_CNT;
            end
        end
    end

    assign stim        = r_stim;
    assign stim_valid  = w_valid;
    assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);
    assign signature   = r_sig;
    assign vec_cnt     = r_vec_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ccg_sig_harness.sv
// Bench for ccg_sig_harness: three instances (LAT 0 configurable netlist,
// LAT 3 registered identity, LAT 0 balanced/faulty netlist) vs a vector-list model.
module tb_ccg_sig_harness;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [12:0] seed = '0;
    logic [13:0] n_vec = '0;

    logic [12:0] a_stim, b_stim, c_stim;
    logic        a_valid, b_valid, c_valid;
    logic        a_busy, b_busy, c_busy;
    logic        a_done, b_done, c_done;
    logic [15:0] a_resp, b_resp, c_resp;
    logic [15:0] a_sig, b_sig, c_sig;
    logic [13:0] a_cnt, b_cnt, c_cnt;
    logic [1:0]  a_st, b_st, c_st;

    int          sel_a = 0;
    logic [15:0] const_a = '0;
    logic [15:0] const_b = '0;
    logic        c_fault = 1'b0;
    logic [12:0] pipe1 = '0, pipe2 = '0, pipe3 = '0;

    logic [12:0] vec_q[$];
    logic [15:0] pre_a[$], pre_b[$], pre_c[$];
    logic [15:0] prev_sig [3] = '{16'h0, 16'h0, 16'h0};
    logic [13:0] prev_cnt [3] = '{14'h0, 14'h0, 14'h0};
    int          run_t = 0;
    bit          has_run = 1'b0;
    int          lat_b = 3;
    int          edges = 0;
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] orig_sig;

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    ccg_sig_harness #(.DUT_LAT(0)) u_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .n_vec(n_vec),
        .stim(a_stim), .stim_valid(a_valid), .resp(a_resp), .busy(a_busy), .done(a_done),
        .signature(a_sig), .vec_cnt(a_cnt), .o_dbg_state(a_st));
    ccg_sig_harness #(.DUT_LAT(3)) u_b (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .n_vec(n_vec),
        .stim(b_stim), .stim_valid(b_valid), .resp(b_resp), .busy(b_busy), .done(b_done),
        .signature(b_sig), .vec_cnt(b_cnt), .o_dbg_state(b_st));
    ccg_sig_harness #(.DUT_LAT(0)) u_c (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .n_vec(n_vec),
        .stim(c_stim), .stim_valid(c_valid), .resp(c_resp), .busy(c_busy), .done(c_done),
        .signature(c_sig), .vec_cnt(c_cnt), .o_dbg_state(c_st));

    function automatic logic [12:0] lfsr_next(input logic [12:0] s);
        return (s >> 1) ^ (s[0] ? 13'h100D : 13'h0000);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ r;
    endfunction

    // Benchmark netlist: ORIGINAL sums serially, BALANCED sums as a tree.
    function automatic logic [15:0] orig_f(input logic [12:0] x);
        logic [15:0] p, q, r;
        p = {3'b0, x};
        q = {5'b0, x[12:2]};
        r = {3'b0, x & 13'h155A};
        return ((p + q) + r) ^ {x[7:0], x[12:5]};
    endfunction

    function automatic logic [15:0] bal_f(input logic [12:0] x, input logic fault);
        logic [15:0] p, q, r, s;
        p = {3'b0, x};
        q = {5'b0, x[12:2]};
        r = {3'b0, x & 13'h155A};
        s = p + (q + r);
        if (fault && x[0] && x[1]) s[4] = ~s[4];
        return s ^ {x[7:0], x[12:5]};
    endfunction

    function automatic logic [15:0] net_a(input int sel, input logic [12:0] x,
                                          input logic [15:0] ca, input logic [15:0] cb);
        case (sel)
            0:       return {3'b0, x};
            1:       return orig_f(x);
            default: return (x == 13'h1) ? ca : cb;
        endcase
    endfunction

    always_comb a_resp = net_a(sel_a, a_stim, const_a, const_b);
    always_comb c_resp = bal_f(c_stim, c_fault);
    always @(posedge clk) begin
        pipe1 <= b_stim;
        pipe2 <= pipe1;
        pipe3 <= pipe2;
    end
    assign b_resp = {3'b0, pipe3};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic chk_ne(input string nm, input logic [31:0] act, input logic [31:0] other);
        n_total++;
        if (act !== other) n_pass++;
        else $display("FAIL %s: got 0x%0h required different from 0x%0h", nm, act, other);
    endtask

    function automatic logic [15:0] pre_at(input int inst, input int k);
        case (inst)
            0:       return pre_a[k];
            1:       return pre_b[k];
            default: return pre_c[k];
        endcase
    endfunction

    task automatic check_inst(input int inst, input string nm, input int lat,
                              input logic v, input logic [12:0] st, input logic b,
                              input logic d, input logic [15:0] sg, input logic [13:0] vc);
        int rel, k, nv;
        logic ev, eb, ed;
        logic [15:0] es;
        logic [13:0] ec;
        ev = 1'b0; eb = 1'b0; ed = 1'b0;
        es = prev_sig[inst];
        ec = prev_cnt[inst];
        rel = -1;
        nv = vec_q.size();
        if (has_run) begin
            rel = edges - run_t;
            if (rel >= 0) begin
                ev = (rel < nv);
                eb = (rel < nv + lat);
                ed = (rel == nv + lat);
                k = rel - lat;
                if (k < 0) k = 0;
                if (k > nv) k = nv;
                es = pre_at(inst, k);
                ec = 14'(k);
            end
        end
        chk({nm, "_valid"}, 32'(v), 32'(ev));
        chk({nm, "_busy"}, 32'(b), 32'(eb));
        chk({nm, "_done"}, 32'(d), 32'(ed));
        chk({nm, "_sig"}, 32'(sg), 32'(es));
        chk({nm, "_cnt"}, 32'(vc), 32'(ec));
        if (ev) chk({nm, "_stim"}, 32'(st), 32'(vec_q[rel]));
        if (rst) chk({nm, "_stim_rst"}, 32'(st), 32'h0);
    endtask

    always @(negedge clk) begin
        check_inst(0, "a", 0, a_valid, a_stim, a_busy, a_done, a_sig, a_cnt);
        check_inst(1, "b", lat_b, b_valid, b_stim, b_busy, b_done, b_sig, b_cnt);
        check_inst(2, "c", 0, c_valid, c_stim, c_busy, c_done, c_sig, c_cnt);
    end

    // Called in an idle cycle just after a rising edge; returns in the first idle cycle.
    task automatic do_run(input logic m, input logic [12:0] s, input logic [13:0] nv,
                          input int sel, input logic [15:0] ca, input logic [15:0] cb,
                          input logic cf, input int pulse_rel, input int rst_rel);
        logic [12:0] x;
        int total;
        if (has_run) begin
            prev_sig[0] = pre_a[$];
            prev_sig[1] = pre_b[$];
            prev_sig[2] = pre_c[$];
            for (int i = 0; i < 3; i++) prev_cnt[i] = 14'(vec_q.size());
        end
        vec_q.delete();
        if (!m) begin
            for (int i = 0; i < 8192; i++) vec_q.push_back(13'(i));
        end else begin
            x = (s == 13'h0) ? 13'h1 : s;
            for (int i = 0; i < int'(nv); i++) begin
                vec_q.push_back(x);
                x = lfsr_next(x);
            end
        end
        pre_a.delete(); pre_b.delete(); pre_c.delete();
        pre_a.push_back(16'h0); pre_b.push_back(16'h0); pre_c.push_back(16'h0);
        foreach (vec_q[i]) begin
            pre_a.push_back(misr_step(pre_a[$], net_a(sel, vec_q[i], ca, cb)));
            pre_b.push_back(misr_step(pre_b[$], {3'b0, vec_q[i]}));
            pre_c.push_back(misr_step(pre_c[$], bal_f(vec_q[i], cf)));
        end
        lat_b = (m && nv == 14'h0) ? 0 : 3;
        total = vec_q.size() + lat_b;
        sel_a = sel; const_a = ca; const_b = cb; c_fault = cf;
        mode = m; seed = s; n_vec = nv; start = 1'b1;
        run_t = edges + 1;
        has_run = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int rel = 0; rel <= total; rel++) begin
            mode = 1'($urandom);
            seed = 13'($urandom);
            n_vec = 14'($urandom);
            start = (rel == pulse_rel);
            if (rel == rst_rel) begin
                rst = 1'b1;
                start = 1'b0;
                has_run = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    prev_sig[i] = 16'h0;
                    prev_cnt[i] = 14'h0;
                end
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int nv;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        chk("pin_lfsr_1", 32'(lfsr_next(13'h0001)), 32'h100D);
        chk("pin_lfsr_2", 32'(lfsr_next(13'h100D)), 32'h180B);
        chk("pin_misr_a5", 32'(misr_step(16'h0000, 16'hA5A5)), 32'hA5A5);
        chk("pin_misr_fb", 32'(misr_step(16'h8000, 16'h0000)), 32'h1021);

        do_run(1'b1, 13'h1, 14'd1, 2, 16'hA5A5, 16'h0000, 1'b0, -1, -1);
        chk("one_vec_sig", 32'(a_sig), 32'hA5A5);
        chk("one_vec_cnt", 32'(a_cnt), 32'd1);

        do_run(1'b1, 13'h1, 14'd2, 2, 16'h8000, 16'h0000, 1'b0, -1, -1);
        chk("two_vec_sig", 32'(a_sig), 32'h1021);

        do_run(1'b1, 13'h0, 14'd3, 0, 16'h0, 16'h0, 1'b0, 1, -1);
        chk("seed0_v0", 32'(vec_q[0]), 32'h0001);
        chk("seed0_v1", 32'(vec_q[1]), 32'h100D);
        chk("seed0_v2", 32'(vec_q[2]), 32'h180B);
        chk("lat_identity_sig", 32'(b_sig), 32'(a_sig));

        do_run(1'b1, 13'h0ABC, 14'd0, 1, 16'h0, 16'h0, 1'b0, -1, -1);
        chk("nvec0_cnt", 32'(a_cnt), 32'd0);

        do_run(1'b0, 13'h0, 14'd0, 1, 16'h0, 16'h0, 1'b0, 100, -1);
        chk("equiv_orig_bal", 32'(c_sig), 32'(a_sig));
        chk("exh_cnt", 32'(a_cnt), 32'd8192);
        orig_sig = pre_a[$];

        do_run(1'b0, 13'h0, 14'd0, 2, 16'h0, 16'h0, 1'b1, 8192, -1);
        chk("zero_netlist_sig", 32'(a_sig), 32'h0);
        chk("zero_netlist_cnt", 32'(a_cnt), 32'd8192);
        chk_ne("fault_detect", 32'(c_sig), 32'(orig_sig));

        do_run(1'b1, 13'h0777, 14'd60, 1, 16'h0, 16'h0, 1'b0, -1, 20);
        chk("abort_sig", 32'(a_sig), 32'h0);
        chk("abort_cnt", 32'(b_cnt), 32'h0);

        repeat (10) begin
            nv = $urandom_range(1, 300);
            do_run(1'b1, 13'($urandom), 14'(nv), $urandom_range(0, 2), 16'($urandom),
                   16'($urandom), 1'($urandom), $urandom_range(0, nv), -1);
        end
        do_run(1'b1, 13'h1234, 14'd40, 0, 16'h0, 16'h0, 1'b0, 5, -1);
        chk("lat_identity_sig2", 32'(b_sig), 32'(a_sig));

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
